// File: rtl/diff_engine_sched.sv
// Round-robin scheduler sharing one f(n)=2n^2+3n+5 difference engine among four requesters.
// Owns the engine start/done handshake, holds the operand, and recovers from a hung engine via a watchdog.
module diff_engine_sched #(
    parameter int unsigned TIMEOUT = 127
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  req_i,
    input  logic [23:0] n_req_i,
    output logic [3:0]  grant_o,
    output logic [3:0]  resp_valid_o,
    output logic [12:0] resp_data_o,
    output logic        resp_err_o,
    output logic        eng_start_o,
    output logic [5:0]  eng_n_o,
    input  logic [12:0] eng_data_out_i,
    input  logic        eng_done_tick_i,
    output logic        eng_reset_o
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned NW   = 6;
    localparam int unsigned RW   = 13;
    localparam int unsigned CW   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;

    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [RW-1:0]   resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic            eng_start_q, eng_start_d;
    logic [NW-1:0]   eng_n_q, eng_n_d;
    logic            eng_reset_q, eng_reset_d;

    logic            sel_found_c;
    logic [IDW-1:0]  sel_id_c;

    // First requester at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        logic [IDW-1:0] idx;
        sel_found_c = 1'b0;
        sel_id_c    = rr_ptr_q;
        idx         = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr_q + IDW'(k);
            if (!sel_found_c && req_i[idx]) begin
                sel_found_c = 1'b1;
                sel_id_c    = idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            id_q         <= '0;
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_n_q      <= '0;
            eng_reset_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            grant_q      <= grant_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            eng_start_q  <= eng_start_d;
            eng_n_q      <= eng_n_d;
            eng_reset_q  <= eng_reset_d;
        end
    end

    // Output registers are loaded one state early so they are high during the named state.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        grant_d      = '0;
        resp_valid_d = '0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        eng_start_d  = 1'b0;
        eng_n_d      = eng_n_q;
        eng_reset_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sel_found_c) begin
                    id_d        = sel_id_c;
                    eng_n_d     = n_req_i[sel_id_c*NW +: NW];
                    grant_d     = NREQ'(1) << sel_id_c;
                    eng_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes priority over the watchdog firing in the same cycle.
                if (eng_done_tick_i) begin
                    resp_valid_d = NREQ'(1) << id_q;
                    resp_data_d  = eng_data_out_i;
                    state_d      = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_valid_d = NREQ'(1) << id_q;
                    resp_err_d   = 1'b1;
                    eng_reset_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                rr_ptr_d = id_q + IDW'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign grant_o      = grant_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign eng_start_o  = eng_start_q;
    assign eng_n_o      = eng_n_q;
    assign eng_reset_o  = eng_reset_q;

endmodule

// File: tb/tb_diff_engine_sched.sv
// Bench for diff_engine_sched: directed and random transactions against an engine stub,
// with grant order, latency and result predicted from the round-robin and polynomial rules.
module tb_diff_engine_sched;

    localparam int TIMEOUT = 127;

    logic        clk;
    logic        reset_i;
    logic [3:0]  req_i;
    logic [23:0] n_req_i;
    logic [3:0]  grant_o;
    logic [3:0]  resp_valid_o;
    logic [12:0] resp_data_o;
    logic        resp_err_o;
    logic        eng_start_o;
    logic [5:0]  eng_n_o;
    logic [12:0] eng_data;
    logic        eng_done_tick;
    logic        eng_reset_o;

    int tests = 0;
    int fails = 0;
    int ptr   = 0;

    int          cfg_done = 3;
    int          stub_left = 0;
    bit          stub_busy = 0;
    logic        stub_done = 1'b0;
    logic        stray = 1'b0;
    logic [12:0] stub_res = '0;
    logic [12:0] noise = '0;

    diff_engine_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_i          (req_i),
        .n_req_i        (n_req_i),
        .grant_o        (grant_o),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_err_o     (resp_err_o),
        .eng_start_o    (eng_start_o),
        .eng_n_o        (eng_n_o),
        .eng_data_out_i (eng_data),
        .eng_done_tick_i(eng_done_tick),
        .eng_reset_o    (eng_reset_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_f(input int n);
        return 2 * n * n + 3 * n + 5;
    endfunction

    // Engine stub: done pulses in absolute cycle cfg_done (counting START as cycle 1); cfg_done<0 hangs.
    always @(negedge clk) begin
        stub_done = 1'b0;
        if (stub_busy) begin
            stub_left = stub_left - 1;
            if (stub_left == 0) begin
                stub_done = 1'b1;
                stub_busy = 0;
            end
        end
        if (eng_start_o === 1'b1) begin
            stub_busy = (cfg_done >= 2);
            stub_left = cfg_done - 1;
            stub_res  = 13'(ref_f(int'(eng_n_o)));
        end
        noise = 13'($urandom);
        if (reset_i) begin
            stub_busy = 0;
            stub_done = 1'b0;
        end
    end

    assign eng_done_tick = stub_done | stray;
    assign eng_data      = eng_done_tick ? stub_res : noise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant_o), 0);
        chk({tag, "_resp_valid"}, 32'(resp_valid_o), 0);
        chk({tag, "_resp_data"}, 32'(resp_data_o), 0);
        chk({tag, "_resp_err"}, 32'(resp_err_o), 0);
        chk({tag, "_eng_start"}, 32'(eng_start_o), 0);
        chk({tag, "_eng_n"}, 32'(eng_n_o), 0);
        chk({tag, "_eng_reset"}, 32'(eng_reset_o), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        req_i   = '0;
        @(negedge clk);
        chk_zero("reset");
        reset_i = 1'b0;
        ptr     = 0;
    endtask

    // Called at a negedge while the DUT is idle; this cycle is cycle 0. Returns in the following IDLE cycle.
    task automatic txn(input logic [3:0] r, input logic [23:0] nv, input int dcyc);
        int id, n, exp_cyc, exp_data, cyc;
        bit exp_err;
        id = -1;
        for (int k = 0; k < 4; k++) begin
            if (id < 0 && r[(ptr + k) % 4]) id = (ptr + k) % 4;
        end
        n = int'((nv >> (6 * id)) & 24'h3f);
        if (dcyc >= 0 && dcyc <= TIMEOUT + 1) begin
            exp_cyc  = dcyc + 1;
            exp_err  = 0;
            exp_data = ref_f(n);
        end else begin
            exp_cyc  = TIMEOUT + 2;
            exp_err  = 1;
            exp_data = 0;
        end
        req_i    = r;
        n_req_i  = nv;
        cfg_done = dcyc;
        @(negedge clk);
        chk("grant", 32'(grant_o), 32'(1 << id));
        chk("eng_start", 32'(eng_start_o), 1);
        chk("eng_n_start", 32'(eng_n_o), 32'(n));
        cyc = 1;
        while (resp_valid_o === 4'b0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (resp_valid_o === 4'b0) begin
                chk("eng_n_hold", 32'(eng_n_o), 32'(n));
                if (cyc == 2) chk("eng_start_low", 32'(eng_start_o), 0);
            end
        end
        chk("resp_cycle", 32'(cyc), 32'(exp_cyc));
        chk("resp_valid", 32'(resp_valid_o), 32'(1 << id));
        chk("resp_data", 32'(resp_data_o), 32'(exp_data));
        chk("resp_err", 32'(resp_err_o), 32'(exp_err));
        chk("eng_reset", 32'(eng_reset_o), 32'(exp_err));
        ptr = (id + 1) % 4;
        @(negedge clk);
        chk("post_resp_valid", 32'(resp_valid_o), 0);
        chk("post_resp_data", 32'(resp_data_o), 0);
        chk("post_eng_reset", 32'(eng_reset_o), 0);
    endtask

    initial begin
        logic [3:0]  r;
        logic [23:0] nv;
        int          id, n;
        reset_i = 1'b1;
        req_i   = '0;
        n_req_i = '0;
        repeat (2) @(negedge clk);
        chk_zero("por");
        reset_i = 1'b0;

        // Single request, n=0.
        txn(4'b0001, 24'd0, 3);
        // req[1] n=3, then req[3] n=63 (worst engine finish).
        txn(4'b0010, 24'(3 << 6), 6);
        txn(4'b1000, 24'(63 << 18), 66);

        // All requesters held from reset.
        do_reset();
        for (int i = 0; i < 5; i++) txn(4'b1111, 24'hABCDEF, 3 + ((24'hABCDEF >> (6 * ptr)) & 24'h3f));

        // Two requesters held continuously must alternate.
        for (int i = 0; i < 4; i++) begin
            id = (ptr <= 0 || ptr > 2) ? 0 : 2;
            txn(4'b0101, 24'h5A5A5A, 3 + int'((24'h5A5A5A >> (6 * id)) & 24'h3f));
        end

        // Hung engine, then normal service.
        txn(4'b0010, 24'(5 << 6), -1);
        txn(4'b0100, 24'(9 << 12), 12);

        // Watchdog boundary: done on the last WAIT cycle wins; one cycle later is a timeout.
        txn(4'b1000, 24'(17 << 18), TIMEOUT + 1);
        txn(4'b0001, 24'd21, TIMEOUT + 2);

        // Stray done while idle must be ignored.
        req_i = '0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_resp_valid", 32'(resp_valid_o), 0);
        @(negedge clk);
        chk("stray_resp_valid2", 32'(resp_valid_o), 0);
        chk("stray_grant", 32'(grant_o), 0);

        // Random traffic with natural engine latency.
        for (int i = 0; i < 10; i++) begin
            r  = 4'($urandom_range(1, 15));
            nv = 24'($urandom);
            id = -1;
            for (int k = 0; k < 4; k++) if (id < 0 && r[(ptr + k) % 4]) id = (ptr + k) % 4;
            n = int'((nv >> (6 * id)) & 24'h3f);
            txn(r, nv, n + 3);
        end

        // Asynchronous reset mid-WAIT.
        req_i    = 4'b0001;
        n_req_i  = 24'd40;
        cfg_done = 43;
        repeat (20) @(negedge clk);
        #2;
        reset_i = 1'b1;
        req_i   = '0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid_o), 0);
        reset_i = 1'b0;
        ptr     = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_rst_resp_valid", 32'(resp_valid_o), 0);
        end
        txn(4'b0100, 24'(11 << 12), 14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
